// File: rtl/s2_tensor_sequencer_if.sv
// Purpose: bundles the run-control, datapath-address and result-stream signals of s2_tensor_sequencer.
// Latency: wires only, no storage.
// Backpressure: out_valid/out_ready handshake on the stream; run control and datapath side have none.
// Ports (master = sequencer view):
//   start in, busy/done out         run control
//   proc_en/filter/row/col out      address issued to the tensor datapath
//   proc_result in                  post-ReLU result returned by the datapath
//   out_valid/data/index/last out,  result stream towards the consumer
//   out_ready in
interface s2_tensor_sequencer_if #(
    parameter int DWIDTH = 36
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     proc_en;
    logic [1:0]               proc_filter;
    logic [2:0]               proc_row;
    logic [2:0]               proc_col;
    logic signed [DWIDTH-1:0] proc_result;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out_data;
    logic [7:0]               out_index;
    logic                     out_last;

    modport master (
        input  start,
        output busy, done,
        output proc_en, proc_filter, proc_row, proc_col,
        input  proc_result,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        output start,
        input  busy, done,
        input  proc_en, proc_filter, proc_row, proc_col,
        output proc_result,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/s2_tensor_sequencer.sv
// Purpose: sweeps every (filter,row,col) position through the tensor datapath, buffers the results, then streams them in index order.
// Latency: first stream word PROC_LAT+1 cycles after the last address issue; one word per accepted handshake.
// Backpressure: out_ready=0 holds the current stream word stable; the compute sweep itself never stalls.
// Ports: clk, rst_n (async active-low) plain; everything else through s2_tensor_sequencer_if.master (bus).
module s2_tensor_sequencer #(
    parameter int DWIDTH   = 36,
    parameter int NFILT    = 4,
    parameter int OUT_DIM  = 6,
    parameter int PROC_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    s2_tensor_sequencer_if.master bus
);
    localparam int         NPOS       = NFILT * OUT_DIM * OUT_DIM;
    localparam logic [7:0] LAST_IDX   = 8'(NPOS - 1);
    localparam logic [1:0] LAST_FILT  = 2'(NFILT - 1);
    localparam logic [2:0] LAST_RC    = 3'(OUT_DIM - 1);
    localparam logic [7:0] FLUSH_LAST = (PROC_LAT > 0) ? 8'(PROC_LAT - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, STREAM} state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_proc_en;
    logic [1:0]               r_filt;
    logic [2:0]               r_row;
    logic [2:0]               r_col;
    logic [7:0]               r_flush;
    logic                     r_out_valid;
    logic signed [DWIDTH-1:0] r_out_data;
    logic [7:0]               r_out_index;
    logic                     r_out_last;
    logic signed [DWIDTH-1:0] r_buf [NPOS];

    logic [7:0] w_issue_idx;
    logic [7:0] w_next_idx;
    logic       w_wr_en;
    logic [7:0] w_wr_idx;

    // Address registers read 0 whenever proc_en is low, so this is 0 too then.
    assign w_issue_idx = 8'(r_filt) * 8'(OUT_DIM * OUT_DIM) + 8'(r_row) * 8'(OUT_DIM) + 8'(r_col);
    assign w_next_idx  = r_out_index + 8'd1;

    // Align the write strobe/index with the datapath latency.
    generate
        if (PROC_LAT == 0) begin : g_comb
            assign w_wr_en  = r_proc_en;
            assign w_wr_idx = w_issue_idx;
        end else begin : g_pipe
            logic       r_pipe_en  [PROC_LAT];
            logic [7:0] r_pipe_idx [PROC_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PROC_LAT; i++) begin
                        r_pipe_en[i]  <= 1'b0;
                        r_pipe_idx[i] <= 8'd0;
                    end
                end else begin
                    r_pipe_en[0]  <= r_proc_en;
                    r_pipe_idx[0] <= w_issue_idx;
                    for (int i = 1; i < PROC_LAT; i++) begin
                        r_pipe_en[i]  <= r_pipe_en[i-1];
                        r_pipe_idx[i] <= r_pipe_idx[i-1];
                    end
                end
            end
            assign w_wr_en  = r_pipe_en[PROC_LAT-1];
            assign w_wr_idx = r_pipe_idx[PROC_LAT-1];
        end
    endgenerate

    // Result buffer is not reset: every run rewrites all entries before streaming.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= bus.proc_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_proc_en   <= 1'b0;
            r_filt      <= 2'd0;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_flush     <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= 8'd0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= COMPUTE;
                        r_busy    <= 1'b1;
                        r_proc_en <= 1'b1;
                        r_filt    <= 2'd0;
                        r_row     <= 3'd0;
                        r_col     <= 3'd0;
                    end
                end
                COMPUTE: begin
                    if (r_filt == LAST_FILT && r_row == LAST_RC && r_col == LAST_RC) begin
                        r_proc_en <= 1'b0;
                        r_filt    <= 2'd0;
                        r_row     <= 3'd0;
                        r_col     <= 3'd0;
                        if (PROC_LAT == 0) begin
                            // Entry 0 was written long ago, so word 0 can be loaded now.
                            r_state     <= STREAM;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_buf[0];
                            r_out_index <= 8'd0;
                            r_out_last  <= (LAST_IDX == 8'd0);
                        end else begin
                            r_state <= FLUSH;
                            r_flush <= 8'd0;
                        end
                    end else if (r_col == LAST_RC) begin
                        r_col <= 3'd0;
                        if (r_row == LAST_RC) begin
                            r_row  <= 3'd0;
                            r_filt <= r_filt + 2'd1;
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                end
                FLUSH: begin
                    // Last in-flight result lands on the edge that leaves FLUSH.
                    if (r_flush == FLUSH_LAST) begin
                        r_state     <= STREAM;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_buf[0];
                        r_out_index <= 8'd0;
                        r_out_last  <= (LAST_IDX == 8'd0);
                        r_flush     <= 8'd0;
                    end else begin
                        r_flush <= r_flush + 8'd1;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (r_out_index == LAST_IDX) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_index <= 8'd0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_data  <= r_buf[w_next_idx];
                            r_out_index <= w_next_idx;
                            r_out_last  <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.proc_en     = r_proc_en;
    assign bus.proc_filter = r_filt;
    assign bus.proc_row    = r_row;
    assign bus.proc_col    = r_col;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_index   = r_out_index;
    assign bus.out_last    = r_out_last;
endmodule

// File: tb/tb_s2_tensor_sequencer.sv
// Purpose: runs a zero-latency and a two-cycle-latency sequencer side by side against a random result table.
// Latency: expects first stream word one cycle after the last issue, plus PROC_LAT.
// Backpressure: drives out_ready always-on, alternating and random; expects held words while stalled.
module tb_s2_tensor_sequencer;
    localparam int DW   = 36;
    localparam int NPOS = 144;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic ready;
    always #5 clk = ~clk;

    s2_tensor_sequencer_if #(.DWIDTH(DW)) if0 ();
    s2_tensor_sequencer_if #(.DWIDTH(DW)) if2 ();

    s2_tensor_sequencer #(.DWIDTH(DW), .NFILT(4), .OUT_DIM(6), .PROC_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    s2_tensor_sequencer #(.DWIDTH(DW), .NFILT(4), .OUT_DIM(6), .PROC_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    logic signed [DW-1:0] tbl [NPOS];

    function automatic int pos_idx(input logic [1:0] f, input logic [2:0] r, input logic [2:0] c);
        return int'(f) * 36 + int'(r) * 6 + int'(c);
    endfunction

    assign if0.start     = start;
    assign if2.start     = start;
    assign if0.out_ready = ready;
    assign if2.out_ready = ready;

    // Datapath stubs: combinational for dut0, two-cycle delayed for dut2.
    assign if0.proc_result = if0.proc_en ? tbl[pos_idx(if0.proc_filter, if0.proc_row, if0.proc_col)] : '0;

    int   d1 = 0, d2 = 0;
    logic e1 = 1'b0, e2 = 1'b0;
    always @(posedge clk) begin
        e1 <= if2.proc_en;
        d1 <= pos_idx(if2.proc_filter, if2.proc_row, if2.proc_col);
        e2 <= e1;
        d2 <= d1;
    end
    assign if2.proc_result = e2 ? tbl[d2] : '0;

    typedef struct {
        logic                 busy, done, en;
        logic [1:0]           f;
        logic [2:0]           r, c;
        logic                 valid;
        logic signed [DW-1:0] data;
        logic [7:0]           idx;
        logic                 last;
    } obs_t;

    obs_t o [2];
    obs_t saved [2];
    int   n_issue [2];
    int   n_word [2];
    int   done_cnt [2];
    int   first_v [2];
    bit   exp_done [2];
    bit   stall [2];
    int   tests = 0;
    int   failed = 0;

    task automatic check(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic grab();
        o[0].busy = if0.busy;  o[0].done = if0.done;  o[0].en = if0.proc_en;
        o[0].f = if0.proc_filter; o[0].r = if0.proc_row; o[0].c = if0.proc_col;
        o[0].valid = if0.out_valid; o[0].data = if0.out_data;
        o[0].idx = if0.out_index; o[0].last = if0.out_last;
        o[1].busy = if2.busy;  o[1].done = if2.done;  o[1].en = if2.proc_en;
        o[1].f = if2.proc_filter; o[1].r = if2.proc_row; o[1].c = if2.proc_col;
        o[1].valid = if2.out_valid; o[1].data = if2.out_data;
        o[1].idx = if2.out_index; o[1].last = if2.out_last;
    endtask

    task automatic check_reset_outs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check(tag, d, {o[d].busy, o[d].done, o[d].en, o[d].f, o[d].r, o[d].c,
                           o[d].valid, o[d].idx, o[d].last}, 64'd0);
            check({tag, "_data"}, d, 64'(o[d].data), 64'd0);
        end
    endtask

    // Compares one DUT against the position/stream model for the current cycle.
    task automatic check_dut(input int d, input bit rdy, input int cyc);
        int k;
        k = n_issue[d];
        if (k > 0 && k < NPOS) check("issue_gap", d, 64'(o[d].en), 64'd1);
        if (o[d].en) begin
            check("issue_overrun", d, 64'(k < NPOS), 64'd1);
            check("issue_pos", d, 64'({o[d].f, o[d].r, o[d].c}),
                  64'(((k / 36) << 6) | (((k % 36) / 6) << 3) | (k % 6)));
            check("busy_issue", d, 64'(o[d].busy), 64'd1);
            n_issue[d]++;
        end else begin
            check("addr_idle", d, 64'({o[d].f, o[d].r, o[d].c}), 64'd0);
        end

        if (exp_done[d]) begin
            check("done_pulse", d, {o[d].done, o[d].valid, o[d].busy}, 64'b100);
            exp_done[d] = 1'b0;
            if (o[d].done) done_cnt[d]++;
        end else begin
            check("done_idle", d, 64'(o[d].done), 64'd0);
        end

        if (stall[d]) begin
            check("hold_valid", d, 64'(o[d].valid), 64'd1);
            check("hold_data", d, 64'(o[d].data), 64'(saved[d].data));
            check("hold_meta", d, 64'({o[d].idx, o[d].last}), 64'({saved[d].idx, saved[d].last}));
        end

        if (o[d].valid) begin
            if (first_v[d] < 0) begin
                first_v[d] = cyc;
                check("stream_after_issue", d, 64'(n_issue[d]), 64'(NPOS));
            end
            if (rdy) begin
                if (n_word[d] < NPOS) begin
                    check("word_index", d, 64'(o[d].idx), 64'(n_word[d]));
                    check("word_data", d, 64'(o[d].data), 64'(tbl[n_word[d]]));
                    check("word_last", d, 64'(o[d].last), 64'(n_word[d] == NPOS - 1));
                    n_word[d]++;
                    if (n_word[d] == NPOS) exp_done[d] = 1'b1;
                end else begin
                    check("extra_word", d, 64'(o[d].valid), 64'd0);
                end
            end
            stall[d] = !rdy;
            saved[d] = o[d];
        end else begin
            stall[d] = 1'b0;
        end
    endtask

    // mode 0: ready always, 1: alternating 1,0, 2: random.
    task automatic run(input int mode, input int restart_at, input int reset_at);
        bit restarted = 1'b0;
        bit aborted   = 1'b0;
        bit finished  = 1'b0;
        for (int i = 0; i < NPOS; i++) begin
            tbl[i] = {4'($urandom_range(15, 0)), 32'($urandom())};
        end
        for (int d = 0; d < 2; d++) begin
            n_issue[d] = 0; n_word[d] = 0; done_cnt[d] = 0; first_v[d] = -1;
            exp_done[d] = 1'b0; stall[d] = 1'b0;
        end
        start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            grab();
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 0);
                default: ready = 1'($urandom_range(1, 0));
            endcase
            if (cyc == 0) begin
                check("issue_start", 0, 64'(o[0].en), 64'd1);
                check("issue_start", 1, 64'(o[1].en), 64'd1);
            end
            check_dut(0, ready, cyc);
            check_dut(1, ready, cyc);
            if (reset_at >= 0 && n_issue[0] == reset_at) begin
                rst_n = 1'b0;
                #1;
                grab();
                check_reset_outs("rst_midrun");
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (restart_at >= 0 && !restarted && n_issue[0] == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (done_cnt[0] == 1 && done_cnt[1] == 1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check("run_done", 0, 64'(done_cnt[0]), 64'd1);
            check("run_done", 1, 64'(done_cnt[1]), 64'd1);
            if (finished) check("lat_delta", 1, 64'(first_v[1] - first_v[0]), 64'd2);
            ready = 1'b1;
            for (int cyc = 0; cyc < 3; cyc++) begin
                @(negedge clk);
                grab();
                check_dut(0, ready, cyc);
                check_dut(1, ready, cyc);
                check("idle_quiet", 0, 64'({o[0].valid, o[0].busy}), 64'd0);
                check("idle_quiet", 1, 64'({o[1].valid, o[1].busy}), 64'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        grab();
        check_reset_outs("rst_init");
        rst_n = 1'b1;
        @(negedge clk);

        run(0, -1, -1);
        run(1, -1, -1);
        run(2, 50, -1);
        run(0, -1, 70);
        run(2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
